// File: rtl/mesh_router_rr.sv
// Five-port input-buffered mesh router with XY routing and per-output round-robin allocation.
// Ports are ordered 0 core, 1 north, 2 east, 3 south, 4 west.
module mesh_router_rr #(
  parameter int DATA_W     = 32,
  parameter int X_W        = 2,
  parameter int Y_W        = 2,
  parameter int X_LOC      = 0,
  parameter int Y_LOC      = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [5*DATA_W-1:0] i_data,
  input  logic [4:0]          i_data_val,
  output logic [4:0]          o_en,
  output logic [5*DATA_W-1:0] o_data,
  output logic [4:0]          o_data_val,
  input  logic [4:0]          i_en
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [X_W-1:0]   X_HERE   = X_W'(X_LOC);
  localparam logic [Y_W-1:0]   Y_HERE   = Y_W'(Y_LOC);
  localparam logic [2:0] P_CORE  = 3'd0;
  localparam logic [2:0] P_NORTH = 3'd1;
  localparam logic [2:0] P_EAST  = 3'd2;
  localparam logic [2:0] P_SOUTH = 3'd3;
  localparam logic [2:0] P_WEST  = 3'd4;

  logic [DATA_W-1:0] mem_p0    [5][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_p0 [5];
  logic [PTR_W-1:0]  rd_ptr_p0 [5];
  logic [CNT_W-1:0]  cnt_p0    [5];
  logic [DATA_W-1:0] head_p0   [5];
  logic [2:0]        route_p0  [5];
  logic [4:0]        vld_p0;
  logic [4:0]        wr;
  logic [4:0]        pop;
  logic [4:0]        req       [5];
  logic [4:0]        can_load;
  logic [4:0]        gnt_vld;
  logic [2:0]        gnt_idx   [5];
  logic [2:0]        rr_ptr    [5];
  logic [DATA_W-1:0] data_p1   [5];
  logic [4:0]        vld_p1;

  // Dimension-order routing: resolve X first, then Y, else deliver locally.
  function automatic logic [2:0] route_xy(input logic [DATA_W-1:0] pkt);
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
    logic [2:0]     port;
    dx = pkt[X_W-1:0];
    dy = pkt[X_W+Y_W-1:X_W];
    if (dx > X_HERE)      port = P_EAST;
    else if (dx < X_HERE) port = P_WEST;
    else if (dy > Y_HERE) port = P_SOUTH;
    else if (dy < Y_HERE) port = P_NORTH;
    else                  port = P_CORE;
    return port;
  endfunction

  // Returns {found, index}; the search starts at ptr and wraps modulo 5.
  function automatic logic [3:0] rr_pick(input logic [4:0] r, input logic [2:0] ptr);
    logic [3:0] pick;
    int         idx;
    pick = '0;
    for (int k = 4; k >= 0; k--) begin
      idx = (int'(ptr) + k) % 5;
      if (r[idx]) pick = {1'b1, 3'(idx)};
    end
    return pick;
  endfunction

  always_comb begin
    for (int p = 0; p < 5; p++) begin
      head_p0[p]  = mem_p0[p][rd_ptr_p0[p]];
      vld_p0[p]   = (cnt_p0[p] != '0);
      route_p0[p] = route_xy(head_p0[p]);
      o_en[p]     = (cnt_p0[p] != FULL_CNT);
      wr[p]       = i_data_val[p] && (cnt_p0[p] != FULL_CNT);
    end
  end

  always_comb begin
    for (int j = 0; j < 5; j++) req[j] = '0;
    for (int p = 0; p < 5; p++) req[route_p0[p]][p] = vld_p0[p];
  end

  always_comb begin
    pop = '0;
    for (int j = 0; j < 5; j++) begin
      can_load[j] = !vld_p1[j] || i_en[j];
      {gnt_vld[j], gnt_idx[j]} = rr_pick(req[j] & {5{can_load[j]}}, rr_ptr[j]);
    end
    for (int j = 0; j < 5; j++) begin
      if (gnt_vld[j]) pop[gnt_idx[j]] = 1'b1;
    end
  end

  // Stage p0: input FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    for (int p = 0; p < 5; p++) begin
      if (wr[p]) mem_p0[p][wr_ptr_p0[p]] <= i_data[p*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int p = 0; p < 5; p++) begin
        wr_ptr_p0[p] <= '0;
        rd_ptr_p0[p] <= '0;
        cnt_p0[p]    <= '0;
        rr_ptr[p]    <= '0;
        data_p1[p]   <= '0;
      end
      vld_p1 <= '0;
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (wr[p])  wr_ptr_p0[p] <= wr_ptr_p0[p] + 1'b1;
        if (pop[p]) rd_ptr_p0[p] <= rd_ptr_p0[p] + 1'b1;
        case ({wr[p], pop[p]})
          2'b10:   cnt_p0[p] <= cnt_p0[p] + 1'b1;
          2'b01:   cnt_p0[p] <= cnt_p0[p] - 1'b1;
          default: cnt_p0[p] <= cnt_p0[p];
        endcase
      end
      // Stage p1: output registers and arbiter pointers
      for (int j = 0; j < 5; j++) begin
        if (gnt_vld[j]) begin
          data_p1[j] <= head_p0[gnt_idx[j]];
          vld_p1[j]  <= 1'b1;
          rr_ptr[j]  <= (gnt_idx[j] == 3'd4) ? 3'd0 : gnt_idx[j] + 3'd1;
        end else if (i_en[j]) begin
          vld_p1[j]  <= 1'b0;
        end
      end
    end
  end

  for (genvar j = 0; j < 5; j++) begin : g_out
    assign o_data[j*DATA_W +: DATA_W] = data_p1[j];
  end
  assign o_data_val = vld_p1;

endmodule

// File: doc/mesh_router_rr.md
Name: mesh_router_rr

Overview:
- Parametrised successor of the 5-port input-buffered mesh router.
- Data width, coordinate widths and FIFO depth are generic.
- Adds per-output round-robin switch allocation, XY dimension-order routing and registered outputs with valid/enable backpressure.
- One instance per mesh node; the ports are [0 core, 1 north, 2 east, 3 south, 4 west].

Parameters:
- DATA_W, 32, packet width in bits (must be >= X_W+Y_W).
- X_W, 2, bits of X coordinate; dest x = packet[X_W-1:0].
- Y_W, 2, bits of Y coordinate; dest y = packet[X_W+Y_W-1:X_W].
- X_LOC, 0, this node's X coordinate.
- Y_LOC, 0, this node's Y coordinate.
- FIFO_DEPTH, 4, entries per input FIFO (power of 2, >= 2).

Ports:
- clk, in, 1, clock.
- reset_n, in, 1, synchronous active-low reset.
- i_data, in, 5*DATA_W, upstream packets; port p occupies bits [p*DATA_W +: DATA_W].
- i_data_val, in, 5, upstream valid per port.
- o_en, out, 5, per-port ready to upstream (input FIFO not full).
- o_data, out, 5*DATA_W, downstream packets, same packing as i_data.
- o_data_val, out, 5, downstream valid per port.
- i_en, in, 5, downstream ready per port.

Behaviour:
- All state is updated on the clk rising edge. Reset is synchronous and active-low.
- Reset values:
  - o_data_val = 0, o_en = 5'b11111, o_data = 0.
  - FIFO read/write pointers and counts = 0.
  - Every round-robin pointer selects input 0 as highest priority.
- Input handshake:
  - A write occurs when i_data_val[p] && o_en[p].
  - o_en[p] = (count[p] != FIFO_DEPTH), decoded from registered count only; there is no same-cycle pop bypass.
  - Valid asserted while o_en is low is ignored; upstream holds the data.
- Route (head of FIFO p, combinational):
  - dest_x > X_LOC -> east; dest_x < X_LOC -> west.
  - Otherwise dest_y > Y_LOC -> south; dest_y < Y_LOC -> north.
  - Otherwise -> core.
  - Out-of-mesh destinations are not checked and exit through the edge port.
- Request: input p requests its routed output only when its FIFO is non-empty. Each input requests exactly one output.
- Output stage:
  - Output j can load when !o_data_val[j] || i_en[j].
  - A downstream transfer occurs when o_data_val[j] && i_en[j].
- Allocation:
  - Per output j, a round-robin arbiter grants one requester, and only when output j can load.
  - On grant: the output register loads the head packet, o_data_val[j] is set next cycle, and FIFO p pops.
  - The pointer moves to (granted index + 1) mod 5.
  - With no grant, the pointer holds. If output j transfers without a new grant, o_data_val[j] clears.
- Latency: a packet accepted at edge t is at the FIFO head after t and appears on o_data/o_data_val at edge t+1. This is 2 cycles of input-to-output valid when uncontested.
- Throughput: 1 packet/cycle per output. A full FIFO with concurrent pop shows o_en=0 that cycle and o_en=1 the next.
- Simultaneous write and pop on the same FIFO: count is unchanged and order is preserved.
- Pointers wrap modulo FIFO_DEPTH.
- Ordering: packets on the same input-to-output path are never reordered.
- Reset mid-operation flushes all FIFOs and output registers. No pre-reset packet may ever appear afterward.

Test Plan:
- Defaults for all cases: DATA_W=16, X_W=2, Y_W=2, X_LOC=1, Y_LOC=1, FIFO_DEPTH=4.
- Core-to-east: inject 16'hA006 on port 0 (x=2, y=1) at cycle 0, with i_en all 1 -> o_data_val[2]=1 and port-2 data 16'hA006 at cycle 2; all other o_data_val stay 0.
- Local delivery: inject 16'h0005 on port 1 (x=1, y=1) -> appears on port 0 two cycles later. Also 16'h0009 (x=1, y=2) -> appears on port 3 (south).
- Contention: ports 1, 3 and 4 each send one packet to east (x=2) in the same cycle after reset -> port-2 outputs in input order 1, 3, 4 on consecutive cycles. A repeated burst, with the pointer now at 0, again yields 1, 3, 4.
- Backpressure: i_en[2]=0; port 4 offers 6 east packets back to back -> 5 accepted (1 in output register, 4 in FIFO), and o_en[4]=0 from the 6th offer. Raising i_en[2] drains them in order, one per cycle, and o_en[4] returns to 1 the cycle after the first pop.
- Reset mid-operation: with 3 packets queued on port 2 and o_data_val[0]=1, hold reset_n=0 for 1 cycle -> next cycle o_data_val=0 and o_en=5'b11111. No queued packet emerges over the following 10 cycles.
- Full-and-pop boundary: fill FIFO 1 to 4 entries, then assert i_en on its output while offering a new packet -> o_en[1]=0 that cycle (packet not accepted) and 1 the next, and the retried packet is accepted.
